// File: rtl/sha256_digest_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_digest_streamer_if
//  Description : Byte-wide valid/ready stream carrying digest symbols from
//                the digest streamer to a UART / SPI / pin adapter.
//                The master drives byte_out, byte_valid and byte_last.
//                The slave drives byte_ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface sha256_digest_streamer_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;

    modport master (
        output byte_out,
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );
endinterface
`default_nettype wire

// File: rtl/sha256_digest_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_digest_streamer
//  Description : Captures the 256-bit SHA-256 digest when digest_valid rises.
//                Streams it most-significant byte first over a valid/ready
//                byte interface.
//                DIGEST_BYTES (1..32) selects how many leading bytes are sent.
//                Optional macro SHA256_STREAM_HEX_EN: when defined, each byte
//                is sent as two lowercase ASCII hex characters, high nibble
//                first. When undefined, raw binary bytes are sent.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_digest_streamer #(
    parameter int DIGEST_BYTES = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [255:0]         digest_in,
    input  wire logic                 digest_valid,
    sha256_digest_streamer_if.master  m_byte,
    output logic                      busy,
    output logic                      overrun
);

    // Number of symbols per digest: one per byte, or two per byte in hex mode.
`ifdef SHA256_STREAM_HEX_EN
    localparam int c_NSYM = 2 * DIGEST_BYTES;
`else
    localparam int c_NSYM = DIGEST_BYTES;
`endif
    localparam logic [6:0] c_LAST = 7'(c_NSYM - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t         r_state;
    logic [255:0]   r_shadow;
    logic [6:0]     r_idx;
    logic           r_valid_prev;
    logic           r_overrun;

    state_t         w_state_nxt;
    logic [255:0]   w_shadow_nxt;
    logic [6:0]     w_idx_nxt;
    logic           w_overrun_nxt;

    logic           w_rise;
    logic           w_sending;

    // A digest_valid high on the first cycle after reset also counts as a rise,
    // because r_valid_prev resets to 0.
    assign w_rise    = digest_valid & ~r_valid_prev;
    assign w_sending = (r_state == S_SEND);

    // ------------------------------------------------------------------------
    // Byte selection: byte 0 is shadow[255:248], byte 31 is shadow[7:0]
    // ------------------------------------------------------------------------
    logic [7:0] w_bytes [0:31];
    logic [4:0] w_byte_idx;
    logic [7:0] w_byte;
    logic [7:0] w_sym;

    for (genvar gi = 0; gi < 32; gi++) begin : g_bytes
        assign w_bytes[gi] = r_shadow[255 - 8*gi -: 8];
    end

`ifdef SHA256_STREAM_HEX_EN
    // Two symbols per byte, so byte index is idx/2.
    // The even symbol carries the high nibble.
    logic [3:0] w_nib;

    assign w_byte_idx = r_idx[5:1];
    assign w_byte     = w_bytes[w_byte_idx];
    assign w_nib      = r_idx[0] ? w_byte[3:0] : w_byte[7:4];
    // '0'..'9' = 0x30..0x39, 'a'..'f' = 0x61..0x66 (0x57 + 10 = 0x61)
    assign w_sym      = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                        : (8'h57 + {4'h0, w_nib});
`else
    assign w_byte_idx = r_idx[4:0];
    assign w_byte     = w_bytes[w_byte_idx];
    assign w_sym      = w_byte;
`endif

    // ------------------------------------------------------------------------
    // Outputs. All are derived from registers only.
    // byte_out is forced to zero outside SEND, so that idle and reset both
    // present 0.
    // ------------------------------------------------------------------------
    assign m_byte.byte_valid = w_sending;
    assign m_byte.byte_out   = w_sending ? w_sym : 8'h00;
    assign m_byte.byte_last  = w_sending && (r_idx == c_LAST);
    assign busy              = (r_state != S_IDLE);
    assign overrun           = r_overrun;

    // Next-state and datapath update: capture on rise in IDLE, advance on transfers in SEND
    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_idx_nxt     = r_idx;
        w_overrun_nxt = r_overrun;

        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_shadow_nxt = digest_in;
                    w_idx_nxt    = 7'd0;
                    w_state_nxt  = S_SEND;
                end
            end

            S_SEND: begin
                // A new digest while streaming is dropped.
                // Only the sticky flag records it.
                if (w_rise) begin
                    w_overrun_nxt = 1'b1;
                end
                if (m_byte.byte_ready) begin
                    if (r_idx == c_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = 7'd0;
                    end else begin
                        w_idx_nxt   = r_idx + 7'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shadow     <= '0;
            r_idx        <= 7'd0;
            r_valid_prev <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow     <= w_shadow_nxt;
            r_idx        <= w_idx_nxt;
            r_valid_prev <= digest_valid;
            r_overrun    <= w_overrun_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_digest_streamer
//  Description : Testbench for sha256_digest_streamer.
//                Two instances run side by side: full (32 bytes) and
//                truncated (28 bytes).
//                A queue-free digest/position model predicts every output on
//                every cycle.
//                Directed scenarios plus randomized traffic drive both DUTs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_digest_streamer;

`ifdef SHA256_STREAM_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif
    localparam int NS0 = HEX ? 64 : 32;
    localparam int NS1 = HEX ? 56 : 28;
    localparam logic [255:0] ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic         clk;
    logic         rst;
    logic [255:0] digest;
    logic         dv;
    logic         busy0, ovr0, busy1, ovr1;

    sha256_digest_streamer_if s0 ();
    sha256_digest_streamer_if s1 ();

    sha256_digest_streamer #(.DIGEST_BYTES(32)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .digest_in    (digest),
        .digest_valid (dv),
        .m_byte       (s0.master),
        .busy         (busy0),
        .overrun      (ovr0)
    );

    sha256_digest_streamer #(.DIGEST_BYTES(28)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .digest_in    (digest),
        .digest_valid (dv),
        .m_byte       (s1.master),
        .busy         (busy1),
        .overrun      (ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Symbol k of a digest, straight from the readout rules.
    function automatic logic [7:0] sym_of(input logic [255:0] d, input int k, input bit hex);
        logic [255:0] t;
        logic [7:0]   b;
        logic [3:0]   nb;
        int           bi;
        bi = hex ? (k / 2) : k;
        t  = d >> (8 * (31 - bi));
        b  = t[7:0];
        if (!hex) return b;
        nb = ((k % 2) == 0) ? b[7:4] : b[3:0];
        if (nb < 4'd10) return 8'(48 + int'(nb));
        return 8'(97 + int'(nb) - 10);
    endfunction

    function automatic int nsym(input int i);
        return (i == 0) ? NS0 : NS1;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model.
    // For each instance it tracks: the captured digest, how many symbols have
    // been accepted, and how many the stream holds.
    // ------------------------------------------------------------------------
    logic [255:0] mdig [2];
    int           mpos [2];
    int           mlen [2];
    bit           movr [2];
    bit           mprev;
    bit           started = 1'b0;
    bit           m_rise;
    bit           m_busy;
    logic         m_rdy;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mdig[i] = '0; mpos[i] = 0; mlen[i] = 0; movr[i] = 1'b0;
        end
        mprev = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mdig[i] = '0; mpos[i] = 0; mlen[i] = 0; movr[i] = 1'b0;
            end
            mprev   = 1'b0;
            started = 1'b1;
        end else begin
            m_rise = dv && !mprev;
            for (int i = 0; i < 2; i++) begin
                m_rdy  = (i == 0) ? s0.byte_ready : s1.byte_ready;
                m_busy = mpos[i] < mlen[i];
                if (m_busy && m_rdy) mpos[i]++;
                if (m_rise) begin
                    if (m_busy) begin
                        movr[i] = 1'b1;
                    end else begin
                        mdig[i] = digest;
                        mpos[i] = 0;
                        mlen[i] = nsym(i);
                    end
                end
            end
            mprev = dv;
        end
    end

    task automatic cmp_inst(input int i, input logic [7:0] bo, input logic bv,
                            input logic bl, input logic bz, input logic ov);
        bit b;
        b = mpos[i] < mlen[i];
        chk($sformatf("u%0d.byte_valid", i), {31'd0, bv}, {31'd0, b});
        chk($sformatf("u%0d.byte_out", i), {24'd0, bo},
            b ? {24'd0, sym_of(mdig[i], mpos[i], HEX)} : 32'd0);
        chk($sformatf("u%0d.byte_last", i), {31'd0, bl},
            {31'd0, b && (mpos[i] == mlen[i] - 1)});
        chk($sformatf("u%0d.busy", i), {31'd0, bz}, {31'd0, b});
        chk($sformatf("u%0d.overrun", i), {31'd0, ov}, {31'd0, movr[i]});
    endtask

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        if (started) begin
            cmp_inst(0, s0.byte_out, s0.byte_valid, s0.byte_last, busy0, ovr0);
            cmp_inst(1, s1.byte_out, s1.byte_valid, s1.byte_last, busy1, ovr1);
        end
    end

    task automatic set_ready(input logic r);
        s0.byte_ready = r;
        s1.byte_ready = r;
    endtask

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom();
        return d;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; dv = 1'b0; digest = '0;
        set_ready(1'b0);

        // Pin the model with hand-derived symbols of the "abc" digest
        chk("pin_bin_0",  {24'd0, sym_of(ABC, 0, 1'b0)},  32'hba);
        chk("pin_bin_1",  {24'd0, sym_of(ABC, 1, 1'b0)},  32'h78);
        chk("pin_bin_27", {24'd0, sym_of(ABC, 27, 1'b0)}, 32'h61);
        chk("pin_bin_31", {24'd0, sym_of(ABC, 31, 1'b0)}, 32'had);
        chk("pin_hex_0",  {24'd0, sym_of(ABC, 0, 1'b1)},  32'h62);
        chk("pin_hex_1",  {24'd0, sym_of(ABC, 1, 1'b1)},  32'h61);
        chk("pin_hex_2",  {24'd0, sym_of(ABC, 2, 1'b1)},  32'h37);
        chk("pin_hex_3",  {24'd0, sym_of(ABC, 3, 1'b1)},  32'h38);
        chk("pin_hex_63", {24'd0, sym_of(ABC, 63, 1'b1)}, 32'h64);

        repeat (3) @(negedge clk);
        chk("rst_byte_out",   {24'd0, s0.byte_out},  32'h0);
        chk("rst_byte_valid", {31'd0, s0.byte_valid}, 32'h0);
        chk("rst_busy",       {31'd0, busy0},         32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Binary/hex readout of "abc" with the sink always ready
        digest = ABC; dv = 1'b1; set_ready(1'b1);
        for (int k = 0; k <= NS0; k++) begin
            @(negedge clk);
            if (k == 0) chk("first_sym", {24'd0, s0.byte_out}, HEX ? 32'h62 : 32'hba);
            if (k == 1) chk("second_sym", {24'd0, s0.byte_out}, HEX ? 32'h61 : 32'h78);
            if (k == NS0 - 1) begin
                chk("last_sym",  {24'd0, s0.byte_out},  HEX ? 32'h64 : 32'had);
                chk("last_flag", {31'd0, s0.byte_last}, 32'h1);
            end
            if (k == NS1 - 1) begin
                chk("trunc_last_sym",  {24'd0, s1.byte_out},  HEX ? 32'h31 : 32'h61);
                chk("trunc_last_flag", {31'd0, s1.byte_last}, 32'h1);
            end
            if (k == NS0) chk("busy_fall", {31'd0, busy0}, 32'h0);
        end
        dv = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure: random stalls on both sinks
        dv = 1'b1;
        repeat (300) begin
            s0.byte_ready = ($urandom_range(0, 1) == 1);
            s1.byte_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        set_ready(1'b1);
        repeat (70) @(negedge clk);
        dv = 1'b0;
        @(negedge clk);

        // Overrun: second rise during byte 5 of the stream
        dv = 1'b1;
        repeat (5) @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        dv = 1'b1; digest = {32{8'h11}};
        @(negedge clk);
        chk("overrun_set", {31'd0, ovr0}, 32'h1);
        repeat (70) @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        dv = 1'b1;
        @(negedge clk);
        chk("second_digest_sym", {24'd0, s0.byte_out}, HEX ? 32'h31 : 32'h11);
        chk("overrun_sticky", {31'd0, ovr0}, 32'h1);
        repeat (70) @(negedge clk);
        dv = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("overrun_clr", {31'd0, ovr0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-stream, with digest_valid held high across reset
        digest = ABC; dv = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_byte_valid", {31'd0, s0.byte_valid}, 32'h0);
        chk("abort_byte_out",   {24'd0, s0.byte_out},   32'h0);
        chk("abort_busy",       {31'd0, busy0},         32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_sym0", {24'd0, s0.byte_out}, HEX ? 32'h62 : 32'hba);
        repeat (70) @(negedge clk);
        dv = 1'b0;

        // Randomized traffic: digest changes every cycle, random toggles,
        // stalls and resets
        repeat (3000) begin
            digest        = rand_digest();
            s0.byte_ready = ($urandom_range(0, 3) != 0);
            s1.byte_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) dv = ~dv;
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0; dv = 1'b0; set_ready(1'b1);
        repeat (80) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
